// File: rtl/serial_sub_16bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per cycle, LSB first.
// Define SERIAL_SUB_SIGNED_OVF_EN for signed overflow; otherwise overflow is the unsigned borrow-out.
module serial_sub_16bit #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 overflow
);

    localparam int CW = $clog2(BIT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [BIT_WIDTH-1:0] a_sh_r;
    logic [BIT_WIDTH-1:0] b_sh_r;
    logic [BIT_WIDTH-1:0] res_r;
    logic                 br_r;
    logic [CW-1:0]        cnt_r;

    logic                 d_s;
    logic                 br_next_s;
    logic                 last_s;
    logic                 ovf_s;
    logic [BIT_WIDTH-1:0] res_next_s;

    // One full-subtractor step: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
        sub_bit = {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
    endfunction

    // Current bit's difference/borrow and the final overflow candidate.
    always_comb begin
        {br_next_s, d_s} = sub_bit(a_sh_r[0], b_sh_r[0], br_r);
        res_next_s       = {d_s, res_r[BIT_WIDTH-1:1]};
        last_s           = (cnt_r == CW'(BIT_WIDTH - 1));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        // On the last step the LSBs of the shifters hold the captured operand MSBs.
        ovf_s = (a_sh_r[0] != b_sh_r[0]) && (d_s != a_sh_r[0]);
`else
        ovf_s = br_next_s;
`endif
    end

    // Status flags come straight from the state register.
    assign busy = (state_r == BUSY);
    assign done = (state_r == DONE);

    // FSM, operand shifters, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_sh_r   <= {BIT_WIDTH{1'b0}};
            b_sh_r   <= {BIT_WIDTH{1'b0}};
            res_r    <= {BIT_WIDTH{1'b0}};
            br_r     <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            diff     <= {BIT_WIDTH{1'b0}};
            overflow <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        br_r    <= borrow_in;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    br_r   <= br_next_s;
                    res_r  <= res_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        diff     <= res_next_s;
                        overflow <= ovf_s;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= BUSY;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_sub_16bit.md
SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 SHALL provide parameter: BIT_WIDTH, default 16, operand/result width (min 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: a  input  BIT_WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port: b  input  BIT_WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port: borrow_in  input  1  initial borrow; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while bits are being computed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when diff/overflow are updated.
REQ-010 SHALL have port: diff  output  BIT_WIDTH  result a - b - borrow_in, modulo 2^BIT_WIDTH.
REQ-011 SHALL have port: overflow  output  1  error flag; meaning set by REQ-031/REQ-032.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; the state register is the only source of busy/done.
REQ-013 In IDLE, start=1 SHALL latch a, b, borrow_in into internal shift registers, clear the bit counter, and enter BUSY next cycle.
REQ-014 In IDLE, start=0 SHALL hold all outputs and internal state.
REQ-015 In BUSY, each cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 Each computed d SHALL shift into the MSB of an internal result register, which shifts right, so that bit i lands at position i after BIT_WIDTH shifts.
REQ-017 BUSY SHALL last exactly BIT_WIDTH cycles; counter width SHALL be $clog2(BIT_WIDTH+1); counter SHALL never wrap inside one operation.
REQ-018 After the BIT_WIDTH-th BUSY cycle the FSM SHALL enter DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-019 On the BUSY->DONE transition, diff and overflow SHALL load the final result; they SHALL then hold until the next DONE or reset.
REQ-020 Latency: start sampled at edge k -> busy=1 in cycles k+1..k+BIT_WIDTH, done=1 in cycle k+BIT_WIDTH+1 (17 cycles after start at default width).
REQ-021 start asserted in BUSY or DONE SHALL be ignored; it SHALL not be queued or change captured operands.
REQ-022 Changes on a, b, or borrow_in after capture SHALL not affect the operation in progress.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 Back-to-back: start held high continuously SHALL give one operation every BIT_WIDTH+2 cycles.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, diff=0, overflow=0, counter=0, internal borrow=0.
REQ-026 rst SHALL take priority over start and over all FSM transitions.
REQ-027 rst asserted mid-BUSY SHALL abort the operation with no done pulse; diff keeps no partial result.
REQ-028 With start=1 and rst=1 in the same cycle, no capture SHALL occur; the first accept is the first edge with rst=0.

Configuration
REQ-029 The macro SERIAL_SUB_SIGNED_OVF_EN SHALL select the overflow definition at compile time.
REQ-030 The FSM, latency and diff SHALL be identical with and without the macro.
REQ-031 Macro defined: overflow SHALL be two's-complement signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operands.
REQ-032 Macro undefined: overflow SHALL be the unsigned borrow-out (final br) after the MSB step.

Verification
REQ-033 a=0x0005, b=0x0003, borrow_in=0, start at edge k -> busy for 16 cycles, done at k+17, diff=0x0002, overflow=0 in both builds.
REQ-034 a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF; overflow=1 without macro, 0 with macro.
REQ-035 a=0x8000, b=0x0001, borrow_in=0 -> diff=0x7FFF; overflow=0 without macro, 1 with macro; then a=0x0003, b=0x0003, borrow_in=1 -> diff=0xFFFF.
REQ-036 Start an operation, toggle start and a/b every cycle during BUSY -> exactly one done pulse, result from the originally captured operands.
REQ-037 Assert rst at BUSY cycle 8 -> next cycle busy=0, done=0, diff=0, overflow=0, and no done pulse follows.
REQ-038 Hold start=1 for 40 cycles with fixed operands -> done pulses at k+17 and k+35; busy and done are never both high.
